// File: rtl/sec_lowest_sched.sv
// sec_lowest_sched: round-robin frame scheduler that time-shares one
// second-lowest-value core among N_CH framed 16-bit sample streams.
// Each grant covers a whole frame: the core is cleared, the frame is
// streamed through a register stage, and the core result is returned with
// channel id, beat count and a degenerate-frame flag.
// Optional feature macro: SEC_LOWEST_SCHED_TIMEOUT_EN (mid-frame stall timeout).
//
// Handshakes: a beat moves on s_* only at a posedge where s_valid[i] and
// s_ready[i] are both high; a result moves at a posedge where res_valid and
// res_ready are both high. s_ready and res_valid are registered and never
// depend combinationally on s_valid or res_ready.
module sec_lowest_sched #(
  parameter int N_CH           = 4,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CW             = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    s_valid,
  input  logic [16*N_CH-1:0] s_data,
  input  logic [N_CH-1:0]    s_last,
  output logic [N_CH-1:0]    s_ready,
  output logic               core_rst_n,
  output logic               core_valid,
  output logic [15:0]        core_data,
  input  logic [15:0]        core_second_lowest,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_data,
  output logic [CW-1:0]      res_chan,
  output logic [15:0]        res_count,
  output logic               res_degenerate,
  output logic               res_abort,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN1 = 3'd3,
    DRAIN2 = 3'd4,
    RESULT = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] pick;
  logic [CW-1:0] pick_next;
  logic [CW:0]   idx;
  logic          found;
  logic          accept;
  logic [15:0]   cur_data;
  logic          cur_last;
  logic [15:0]   clr_cnt;
  logic [15:0]   first_q;
  logic          differs;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // s_ready is one-hot only in STREAM, so this is the granted channel's handshake
  assign accept = (state == STREAM) && |(s_valid & s_ready);

  // Round-robin search starting at rr_ptr for the first requesting channel
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(i);
      if (idx >= (CW+1)'(N_CH)) idx = idx - (CW+1)'(N_CH);
      if (!found && s_valid[idx[CW-1:0]]) begin
        found = 1'b1;
        pick  = idx[CW-1:0];
      end
    end
    pick_next = (pick == CW'(N_CH - 1)) ? '0 : pick + CW'(1);
  end

  // Select the granted channel's beat data and last flag
  always_comb begin
    cur_data = s_data[15:0];
    cur_last = s_last[0];
    for (int i = 0; i < N_CH; i++) begin
      if (res_chan == CW'(i)) begin
        cur_data = s_data[16*i +: 16];
        cur_last = s_last[i];
      end
    end
  end

`ifdef SEC_LOWEST_SCHED_TIMEOUT_EN
  logic        cur_valid;
  logic [15:0] idle_cnt;
  logic        abort_q;
  assign cur_valid = s_valid[res_chan];
  assign res_abort = abort_q;
`else
  assign res_abort = 1'b0;
`endif

  // Frame FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      s_ready        <= '0;
      core_rst_n     <= 1'b0;
      core_valid     <= 1'b0;
      core_data      <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_chan       <= '0;
      res_count      <= '0;
      res_degenerate <= 1'b0;
      clr_cnt        <= '0;
      first_q        <= '0;
      differs        <= 1'b0;
`ifdef SEC_LOWEST_SCHED_TIMEOUT_EN
      idle_cnt       <= '0;
      abort_q        <= 1'b0;
`endif
    end else begin
      core_valid <= 1'b0;
      case (state)
        IDLE: begin
          core_rst_n <= 1'b1;
          if (found) begin
            res_chan       <= pick;
            rr_ptr         <= pick_next;
            res_count      <= '0;
            res_data       <= '0;
            res_degenerate <= 1'b0;
            differs        <= 1'b0;
            clr_cnt        <= '0;
            core_rst_n     <= 1'b0;
            state          <= CLEAR;
`ifdef SEC_LOWEST_SCHED_TIMEOUT_EN
            idle_cnt       <= '0;
            abort_q        <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          if (clr_cnt == 16'(CLR_CYCLES - 1)) begin
            core_rst_n <= 1'b1;
            s_ready    <= N_CH'(1) << res_chan;
            state      <= STREAM;
          end else begin
            clr_cnt <= clr_cnt + 16'd1;
          end
        end
        STREAM: begin
          if (accept) begin
            core_valid <= 1'b1;
            core_data  <= cur_data;
            if (res_count != 16'hFFFF) res_count <= res_count + 16'd1;
            if (res_count == 16'd0) first_q <= cur_data;
            else if (cur_data != first_q) differs <= 1'b1;
            if (cur_last) begin
              s_ready <= '0;
              state   <= DRAIN1;
            end
          end
`ifdef SEC_LOWEST_SCHED_TIMEOUT_EN
          if (accept) begin
            idle_cnt <= '0;
          end else if (!cur_valid) begin
            if (idle_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
              abort_q <= 1'b1;
              s_ready <= '0;
              state   <= DRAIN1;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
`endif
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: begin
          res_data       <= differs ? core_second_lowest : 16'hFFFF;
          res_degenerate <= ~differs;
          res_valid      <= 1'b1;
          state          <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_lowest_sched.sv
// tb_sec_lowest_sched: directed bench for sec_lowest_sched with a behavioural
// second-lowest core, a result scoreboard and cycle-level timing checks.
module tb_sec_lowest_sched;

  localparam int N_CH = 4;
  localparam int CW   = 2;
  localparam int W    = 16 + CW + 16 + 1 + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_CH-1:0]    s_valid = '0;
  logic [16*N_CH-1:0] s_data = '0;
  logic [N_CH-1:0]    s_last = '0;
  logic [N_CH-1:0]    s_ready;
  logic               core_rst_n, core_valid;
  logic [15:0]        core_data, core_second_lowest;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [15:0]        res_data, res_count;
  logic [CW-1:0]      res_chan;
  logic               res_degenerate, res_abort, busy;
  logic [2:0]         state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  sec_lowest_sched #(.N_CH(N_CH), .CLR_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .core_rst_n(core_rst_n), .core_valid(core_valid),
    .core_data(core_data), .core_second_lowest(core_second_lowest),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_chan(res_chan), .res_count(res_count), .res_degenerate(res_degenerate),
    .res_abort(res_abort), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural shared core: tracks lowest and second-lowest distinct values
  logic [15:0] core_low = 16'hFFFF;
  logic [15:0] core_sec = 16'hFFFF;
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_low <= 16'hFFFF;
      core_sec <= 16'hFFFF;
    end else if (core_valid) begin
      if (core_data < core_low) begin
        core_sec <= core_low;
        core_low <= core_data;
      end else if (core_data > core_low && core_data < core_sec) begin
        core_sec <= core_data;
      end
    end
  end
  assign core_second_lowest = core_sec;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected result of a frame, derived directly from its beat values
  task automatic push_exp(input int ch, input int n, input logic [15:0] v[8], input logic abort);
    logic [15:0] mn, sec;
    logic dif;
    mn = 16'hFFFF; sec = 16'hFFFF; dif = 1'b0;
    for (int i = 0; i < n; i++) if (v[i] < mn) mn = v[i];
    for (int i = 0; i < n; i++) if (v[i] > mn && v[i] < sec) sec = v[i];
    for (int i = 1; i < n; i++) if (v[i] != v[0]) dif = 1'b1;
    exp_q.push_back({dif ? sec : 16'hFFFF, CW'(ch), 16'(n), ~dif, abort});
  endtask

  task automatic send_beat(input int ch, input logic [15:0] d, input logic last);
    int guard;
    guard = 0;
    s_valid[ch] = 1'b1;
    s_data[16*ch +: 16] = d;
    s_last[ch] = last;
    while (!s_ready[ch] && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      check("beat_accept_timeout", 40'(guard), 40'd0);
    end else begin
      tick();
      check("core_valid_on_beat", 40'(core_valid), 40'd1);
      check("core_data_on_beat", 40'(core_data), 40'(d));
    end
    s_valid[ch] = 1'b0;
    s_last[ch]  = 1'b0;
  endtask

  task automatic run_frame(input int ch, input int n, input logic [15:0] v[8]);
    push_exp(ch, n, v, 1'b0);
    for (int i = 0; i < n; i++) send_beat(ch, v[i], (i == n - 1));
  endtask

  task automatic wait_res_valid(input string tag);
    int guard;
    guard = 0;
    while (!res_valid && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check(tag, 40'(res_valid), 40'd1);
  endtask

  // scoreboard: compare each consumed result against the expected queue
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 40'(res_data), 40'hFFFFFFFFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("res_data", 40'(res_data), 40'(e[W-1 -: 16]));
        check("res_chan", 40'(res_chan), 40'(e[W-17 -: CW]));
        check("res_count", 40'(res_count), 40'(e[17:2]));
        check("res_degenerate", 40'(res_degenerate), 40'(e[1]));
        check("res_abort", 40'(res_abort), 40'(e[0]));
      end
    end
  end

  logic [15:0] b0[4] = '{16'd100, 16'd200, 16'd300, 16'd50};
  logic [15:0] b2[4] = '{16'd7, 16'd8, 16'd9, 16'd1};

  initial begin
    int i0, i2, guard, ngrant, bad_rdy, cyc;
    logic [N_CH-1:0] rdy, prev_rdy;
    int grant_seen[4];
    int grant_exp[4];
    grant_exp = '{0, 2, 0, 2};

    // reset values
    tick(); tick();
    check("rst_s_ready", 40'(s_ready), 40'd0);
    check("rst_core_rst_n", 40'(core_rst_n), 40'd0);
    check("rst_core_valid", 40'(core_valid), 40'd0);
    check("rst_core_data", 40'(core_data), 40'd0);
    check("rst_res_valid", 40'(res_valid), 40'd0);
    check("rst_res_fields", 40'({res_data, res_count, res_chan, res_degenerate, res_abort}), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    rst = 1'b0;
    tick();

    // ch0 and ch2 competing with 2-beat frames: expect 0,2,0,2
    push_exp(0, 2, '{16'd100, 16'd200, 0, 0, 0, 0, 0, 0}, 1'b0);
    push_exp(2, 2, '{16'd7, 16'd8, 0, 0, 0, 0, 0, 0}, 1'b0);
    push_exp(0, 2, '{16'd300, 16'd50, 0, 0, 0, 0, 0, 0}, 1'b0);
    push_exp(2, 2, '{16'd9, 16'd1, 0, 0, 0, 0, 0, 0}, 1'b0);
    i0 = 0; i2 = 0; guard = 0; ngrant = 0; bad_rdy = 0; prev_rdy = '0;
    while ((i0 < 4 || i2 < 4) && guard < 500) begin
      s_valid[0] = (i0 < 4);
      s_data[15:0] = b0[i0 % 4];
      s_last[0] = (i0 % 2 == 1);
      s_valid[2] = (i2 < 4);
      s_data[47:32] = b2[i2 % 4];
      s_last[2] = (i2 % 2 == 1);
      rdy = s_ready;
      if (rdy[1] || rdy[3]) bad_rdy++;
      if (rdy != '0 && prev_rdy == '0 && ngrant < 4) begin
        grant_seen[ngrant] = rdy[2] ? 2 : 0;
        ngrant++;
      end
      prev_rdy = rdy;
      tick();
      if (rdy[0] && s_valid[0]) i0++;
      if (rdy[2] && s_valid[2]) i2++;
      guard++;
    end
    s_valid = '0; s_last = '0;
    check("rr_frames_done", 40'(i0 + i2), 40'd8);
    check("rr_grant_count", 40'(ngrant), 40'd4);
    for (int k = 0; k < 4; k++) check("rr_grant_order", 40'(grant_seen[k]), 40'(grant_exp[k]));
    check("rr_idle_ch_ready", 40'(bad_rdy), 40'd0);
    tick(); tick(); tick(); tick();

    // ch0 frame 5,3,9,3,1 with clear and result timing
    s_valid[0] = 1'b1;
    s_data[15:0] = 16'd5;
    tick();
    check("clr_core_rst_n_c0", 40'(core_rst_n), 40'd0);
    check("clr_busy", 40'(busy), 40'd1);
    tick();
    check("clr_core_rst_n_c1", 40'(core_rst_n), 40'd0);
    check("clr_s_ready_low", 40'(s_ready), 40'd0);
    tick();
    check("stream_core_rst_n", 40'(core_rst_n), 40'd1);
    check("stream_s_ready", 40'(s_ready), 40'b0001);
    run_frame(0, 5, '{16'd5, 16'd3, 16'd9, 16'd3, 16'd1, 0, 0, 0});
    check("res_valid_e0", 40'(res_valid), 40'd0);
    check("s_ready_after_last", 40'(s_ready), 40'd0);
    tick();
    check("res_valid_e1", 40'(res_valid), 40'd0);
    tick();
    check("res_valid_e2", 40'(res_valid), 40'd1);
    check("res_data_e2", 40'(res_data), 40'd3);
    tick();

    // degenerate frames on ch1
    run_frame(1, 3, '{16'd7, 16'd7, 16'd7, 0, 0, 0, 0, 0});
    run_frame(1, 1, '{16'd42, 0, 0, 0, 0, 0, 0, 0});
    wait_res_valid("degen_res_valid");
    tick(); tick();

    // back-pressure on result port with ch3 requesting
    res_ready = 1'b0;
    run_frame(0, 2, '{16'd4, 16'd2, 0, 0, 0, 0, 0, 0});
    wait_res_valid("bp_res_valid");
    s_valid[3] = 1'b1;
    s_data[63:48] = 16'd11;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_res_valid_held", 40'(res_valid), 40'd1);
      check("bp_res_stable", 40'({res_data, res_count, res_chan}), 40'({16'd4, 16'd2, 2'd0}));
      check("bp_busy", 40'(busy), 40'd1);
      check("bp_s_ready", 40'(s_ready), 40'd0);
    end
    res_ready = 1'b1;
    tick();
    check("bp_res_valid_drop", 40'(res_valid), 40'd0);
    run_frame(3, 2, '{16'd11, 16'd22, 0, 0, 0, 0, 0, 0});
    wait_res_valid("ch3_res_valid");
    tick(); tick();

    // reset mid-frame: frame discarded, arbitration restarts at ch0
    send_beat(1, 16'd500, 1'b0);
    send_beat(1, 16'd600, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_s_ready", 40'(s_ready), 40'd0);
    check("mid_rst_core_rst_n", 40'(core_rst_n), 40'd0);
    check("mid_rst_core_valid", 40'(core_valid), 40'd0);
    check("mid_rst_res", 40'({res_valid, res_count, res_chan}), 40'd0);
    check("mid_rst_busy", 40'(busy), 40'd0);
    tick(); tick();
    rst = 1'b0;
    s_valid[3] = 1'b1;
    s_data[63:48] = 16'd77;
    s_last[3] = 1'b1;
    run_frame(0, 3, '{16'd30, 16'd20, 16'd10, 0, 0, 0, 0, 0});
    run_frame(3, 1, '{16'd77, 0, 0, 0, 0, 0, 0, 0});
    wait_res_valid("post_rst_res_valid");
    tick(); tick();

`ifdef SEC_LOWEST_SCHED_TIMEOUT_EN
    // stall timeout after two beats
    push_exp(2, 2, '{16'd10, 16'd20, 0, 0, 0, 0, 0, 0}, 1'b1);
    send_beat(2, 16'd10, 1'b0);
    send_beat(2, 16'd20, 1'b0);
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("timeout_latency", 40'(cyc), 40'd10);
    tick(); tick();
`else
    cyc = 0;
`endif

    // drain scoreboard
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("scoreboard_empty", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
